// File: rtl/vga_pkg.sv
// Shared constants and types for the rectangle-fill pixel writer.
package vga_pkg;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOR_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [X_W-1:0]     x0;
        logic [Y_W-1:0]     y0;
        logic [X_W-1:0]     width;
        logic [Y_W-1:0]     height;
        logic [COLOR_W-1:0] color;
    } rect_cmd_t;
endpackage

// File: rtl/vga_rect_clip.sv
// Combinational clip of a rectangle command against the frame buffer bounds.
module vga_rect_clip #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic [7:0] x0,
    input  logic [6:0] y0,
    input  logic [7:0] width,
    input  logic [6:0] height,
    output logic [7:0] x_end,
    output logic [6:0] y_end,
    output logic       empty
);
    localparam logic [8:0] X_MAX = 9'(SCREEN_W - 1);
    localparam logic [8:0] Y_MAX = 9'(SCREEN_H - 1);

    logic [8:0] x_last;
    logic [8:0] y_last;

    // 9-bit sums so origin+size never wraps before the min() against the screen edge
    assign x_last = {1'b0, x0} + {1'b0, width} - 9'd1;
    assign y_last = {2'b0, y0} + {2'b0, height} - 9'd1;

    assign x_end = (x_last > X_MAX) ? X_MAX[7:0] : x_last[7:0];
    assign y_end = (y_last > Y_MAX) ? Y_MAX[6:0] : y_last[6:0];

    assign empty = (width == 8'd0) || (height == 7'd0) ||
                   ({1'b0, x0} >= 9'(SCREEN_W)) || ({2'b0, y0} >= 9'(SCREEN_H));
endmodule

// File: rtl/vga_rect_fill.sv
// Rectangle fill engine: one raster-ordered pixel write per unstalled cycle into vga_core.
module vga_rect_fill #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] x0,
    input  logic [6:0] y0,
    input  logic [7:0] width,
    input  logic [6:0] height,
    input  logic [2:0] color_in,
    input  logic       stall,
    output logic       ready,
    output logic       done,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] color,
    output logic       plot
);
    import vga_pkg::*;

    state_t    state_q, state_d;
    rect_cmd_t cmd;
    logic [7:0] x_q, x_start_q, x_end_q, clip_x_end;
    logic [6:0] y_q, y_end_q, clip_y_end;
    logic [2:0] color_q;
    logic       clip_empty, accept, last_px;

    assign cmd = '{x0: x0, y0: y0, width: width, height: height, color: color_in};

    vga_rect_clip #(.SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)) u_clip (
        .x0    (cmd.x0),
        .y0    (cmd.y0),
        .width (cmd.width),
        .height(cmd.height),
        .x_end (clip_x_end),
        .y_end (clip_y_end),
        .empty (clip_empty)
    );

    assign accept  = (state_q == IDLE) && start;
    assign last_px = (x_q == x_end_q) && (y_q == y_end_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = clip_empty ? DONE : FILL;
            FILL:    if (!stall && last_px) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready = (state_q == IDLE);
        done  = (state_q == DONE);
        plot  = (state_q == FILL) && !stall;
    end

    // Position stays on the last written pixel once the fill finishes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_q       <= '0;
            y_q       <= '0;
            color_q   <= '0;
            x_start_q <= '0;
            x_end_q   <= '0;
            y_end_q   <= '0;
        end else if (accept) begin
            x_start_q <= cmd.x0;
            x_end_q   <= clip_x_end;
            y_end_q   <= clip_y_end;
            if (!clip_empty) begin
                x_q     <= cmd.x0;
                y_q     <= cmd.y0;
                color_q <= cmd.color;
            end
        end else if (plot && !last_px) begin
            if (x_q == x_end_q) begin
                x_q <= x_start_q;
                y_q <= y_q + 7'd1;
            end else begin
                x_q <= x_q + 8'd1;
            end
        end
    end

    assign x     = x_q;
    assign y     = y_q;
    assign color = color_q;
endmodule

// File: tb/tb_vga_rect_fill.sv
// Self-checking bench: table of directed commands, random commands, reset mid-fill.
module tb_vga_rect_fill;
    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [7:0] x0;
    logic [6:0] y0;
    logic [7:0] width;
    logic [6:0] height;
    logic [2:0] color_in;
    logic       stall;
    logic       ready, done, plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] color;

    int checks = 0;
    int errors = 0;

    vga_rect_fill #(.SCREEN_W(160), .SCREEN_H(120)) dut (
        .clk(clk), .resetn(resetn), .start(start), .x0(x0), .y0(y0),
        .width(width), .height(height), .color_in(color_in), .stall(stall),
        .ready(ready), .done(done), .x(x), .y(y), .color(color), .plot(plot)
    );

    always #5 clk = ~clk;

    typedef struct {
        int px;
        int py;
        int pc;
    } pix_t;

    typedef struct {
        int cx0, cy0, cw, ch, cc;
        int smode;     // 0 none, 1 random, 2 three cycles after 2nd pixel
        int mid;       // pulse start mid-fill
        int exp_n;
        int exp_lx, exp_ly;
        int exp_fill;  // FILL cycles, -1 = don't check
    } vec_t;

    pix_t exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference: enumerate every on-screen pixel of the rectangle in raster order.
    task automatic model(input int cx0, input int cy0, input int cw, input int ch, input int cc);
        pix_t p;
        exp_q.delete();
        if (cw == 0 || ch == 0 || cx0 >= 160 || cy0 >= 120) return;
        for (int yy = cy0; yy < cy0 + ch && yy < 120; yy++)
            for (int xx = cx0; xx < cx0 + cw && xx < 160; xx++) begin
                p.px = xx; p.py = yy; p.pc = cc;
                exp_q.push_back(p);
            end
    endtask

    task automatic run_cmd(input int cx0, input int cy0, input int cw, input int ch, input int cc,
                           input int smode, input int mid,
                           output int npix, output int lx, output int ly, output int fillc);
        pix_t e;
        int cycles, st_left, expect_empty;
        bit fin, first, prev_plot, used_mid;
        model(cx0, cy0, cw, ch, cc);
        expect_empty = (exp_q.size() == 0);
        npix = 0; lx = -1; ly = -1; fillc = 0;
        @(negedge clk);
        x0 = 8'(cx0); y0 = 7'(cy0); width = 8'(cw); height = 7'(ch); color_in = 3'(cc);
        start = 1'b1; stall = 1'b0;
        #1 chk("ready_before_start", int'(ready), 1);
        @(negedge clk);
        start = 1'b0;
        cycles = 0; fin = 0; first = 1; prev_plot = 0; st_left = 3; used_mid = 0;
        while (!fin && cycles < 25000) begin
            stall = 1'b0;
            start = 1'b0;
            if (smode == 1) stall = ($urandom_range(0, 3) == 0);
            else if (smode == 2 && npix == 2 && st_left > 0) begin
                stall = 1'b1; st_left--;
            end
            if (mid != 0 && npix == 1 && !used_mid) begin
                start = 1'b1; used_mid = 1;
                x0 = 8'($urandom_range(0, 40)); y0 = 7'($urandom_range(0, 40));
                width = 8'($urandom_range(1, 9)); height = 7'($urandom_range(1, 9));
                color_in = 3'($urandom_range(0, 7));
            end
            #1;
            if (done) begin
                chk("pixels_left_at_done", exp_q.size(), 0);
                chk("done_latency", int'(first ? expect_empty != 0 : prev_plot), 1);
                chk("plot_low_in_done", int'(plot), 0);
                fin = 1;
            end else begin
                fillc++;
                chk("ready_low_busy", int'(ready), 0);
                chk("plot_vs_stall", int'(plot), int'(!stall));
                if (plot) begin
                    if (exp_q.size() == 0) chk("extra_plot", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("pix_x", int'(x), e.px);
                        chk("pix_y", int'(y), e.py);
                        chk("pix_color", int'(color), e.pc);
                    end
                    npix++; lx = int'(x); ly = int'(y);
                end
            end
            prev_plot = plot && !done;
            first = 0;
            cycles++;
            @(negedge clk);
        end
        start = 1'b0; stall = 1'b0;
        if (!fin) chk("done_timeout", 0, 1);
        #1;
        chk("ready_after_done", int'(ready), 1);
        chk("done_single_pulse", int'(done), 0);
    endtask

    vec_t vecs[6];
    int n, lx, ly, fc, rcnt;
    bit bad;

    initial begin
        vecs[0] = '{10, 5, 3, 2, 5, 0, 0, 6, 12, 6, 6};
        vecs[1] = '{0, 0, 160, 120, 0, 0, 0, 19200, 159, 119, 19200};
        vecs[2] = '{158, 118, 5, 5, 7, 0, 0, 4, 159, 119, 4};
        vecs[3] = '{20, 20, 0, 3, 1, 0, 0, 0, 0, 0, 0};
        vecs[4] = '{160, 10, 4, 2, 2, 0, 0, 0, 0, 0, 0};
        vecs[5] = '{30, 40, 4, 1, 6, 2, 1, 4, 33, 40, 7};

        resetn = 1'b0; start = 1'b0; stall = 1'b0;
        x0 = '0; y0 = '0; width = '0; height = '0; color_in = '0;
        #1;
        chk("rst_ready", int'(ready), 1);
        chk("rst_done", int'(done), 0);
        chk("rst_plot", int'(plot), 0);
        chk("rst_xyc", int'({x, y, color}), 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            run_cmd(vecs[i].cx0, vecs[i].cy0, vecs[i].cw, vecs[i].ch, vecs[i].cc,
                    vecs[i].smode, vecs[i].mid, n, lx, ly, fc);
            chk($sformatf("vec%0d_count", i), n, vecs[i].exp_n);
            if (vecs[i].exp_n > 0) begin
                chk($sformatf("vec%0d_last_x", i), lx, vecs[i].exp_lx);
                chk($sformatf("vec%0d_last_y", i), ly, vecs[i].exp_ly);
            end
            if (vecs[i].exp_fill >= 0) chk($sformatf("vec%0d_fill_cycles", i), fc, vecs[i].exp_fill);
        end

        for (int r = 0; r < 40; r++)
            run_cmd($urandom_range(0, 170), $urandom_range(0, 127), $urandom_range(0, 20),
                    $urandom_range(0, 10), $urandom_range(0, 7), 1, 0, n, lx, ly, fc);

        // Reset after 50 pixels of a 10x10 fill.
        @(negedge clk);
        x0 = 8'd20; y0 = 7'd30; width = 8'd10; height = 7'd10; color_in = 3'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rcnt = 0;
        for (int c = 0; c < 200 && rcnt < 50; c++) begin
            #1 if (plot) rcnt++;
            @(negedge clk);
        end
        chk("rst_mid_pixels_before", rcnt, 50);
        resetn = 1'b0;
        #1;
        chk("rst_mid_plot", int'(plot), 0);
        chk("rst_mid_ready", int'(ready), 1);
        chk("rst_mid_done", int'(done), 0);
        @(negedge clk);
        resetn = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            #1 if (plot || done || !ready) bad = 1;
            @(negedge clk);
        end
        chk("rst_mid_quiet_after", int'(bad), 0);
        run_cmd(10, 5, 3, 2, 5, 0, 0, n, lx, ly, fc);
        chk("post_reset_count", n, 6);
        chk("post_reset_last", lx * 1000 + ly, 12 * 1000 + 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_rect_fill.md
Name: vga_rect_fill

Overview:
- Pixel-write initiator for the vga_core plot port. Accepts a rectangle command (origin, size, colour) and emits one pixel write per cycle on x/y/color/plot until the clipped rectangle is filled.
- Sits between control logic (CPU/FSM/game logic) and vga_core.
- Also used for screen clear: full-screen rectangle in colour 0.

Parameters:
- SCREEN_W, 160, frame buffer width in pixels
- SCREEN_H, 120, frame buffer height in pixels

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous, active-low reset
- start  input  1  command strobe; accepted only when ready=1
- x0  input  8  rectangle left column
- y0  input  7  rectangle top row
- width  input  8  rectangle width in pixels (0 = empty)
- height  input  7  rectangle height in pixels (0 = empty)
- color_in  input  3  fill colour {R,G,B}
- stall  input  1  arbiter back-pressure; holds the write stream
- ready  output  1  high in IDLE; command can be accepted
- done  output  1  one-cycle pulse on completion
- x  output  8  to vga_core x
- y  output  7  to vga_core y
- color  output  3  to vga_core color
- plot  output  1  to vga_core plot (write enable)

Behaviour:
- Clock is clk. Reset is resetn, asynchronous and active-low.
- Reset values: state=IDLE, ready=1, done=0, plot=0, x=0, y=0, color=0.
- States:
  - IDLE:
    - ready=1.
    - start=1 latches x0, y0, color_in and the clipped end coordinates.
    - Goes to FILL if the rectangle is non-empty, else to DONE.
  - FILL:
    - plot = !stall (combinational from state and stall); x, y, color are registered.
    - On each edge with plot=1 the position advances:
      - if x == x_end then x <= x_start, y <= y+1, else x <= x+1.
    - The write with x==x_end and y==y_end goes to DONE.
  - DONE: done=1 for exactly one cycle, plot=0, then go to IDLE.
- Clipping (9-bit arithmetic):
  - x_end = min(x0+width-1, SCREEN_W-1); y_end = min(y0+height-1, SCREEN_H-1).
  - The rectangle is empty if width==0, height==0, x0>=SCREEN_W or y0>=SCREEN_H.
  - An empty rectangle goes IDLE -> DONE with zero plots. done still pulses.
- Latency:
  - start accepted at edge N; first plot=1 in the cycle after edge N (absent stall).
  - Unstalled fill takes Wc*Hc plot cycles, where Wc/Hc are the clipped width/height.
  - done is high in the cycle immediately after the last plot cycle.
- Pixel order: raster (row-major), left to right, top to bottom.
- start while ready=0: ignored. No queueing, no effect on the fill in progress.
- start and done in the same cycle: ignored (ready=0 in DONE). Accepted from the following IDLE cycle.
- stall:
  - High: plot=0 in that cycle; x/y/state hold.
  - Can be asserted for any duration. No pixel is dropped or duplicated.
  - Has no effect in IDLE or DONE.
- Inputs x0..color_in may change after acceptance without affecting the fill in progress.
- resetn low mid-fill:
  - Immediately (asynchronously) plot=0, done=0, ready=1, state=IDLE.
  - The remaining pixels are abandoned.
- x/y hold the last written coordinate when not in FILL. vga_core ignores them while plot=0.

Decomposition:
- Package vga_pkg:
  - SCREEN_W, SCREEN_H
  - X_W=8, Y_W=7, COLOR_W=3
  - typedef enum state_t {IDLE, FILL, DONE}
  - typedef struct rect_cmd_t {x0, y0, width, height, color}
- One natural sub-module: vga_rect_clip. Purely combinational: command -> x_end, y_end, empty flag.
- Top holds the FSM and the position counters.

Test Plan:
- Unclipped fill: x0=10, y0=5, w=3, h=2, color=3'b101, no stall.
  - Required: exactly 6 plots at (10,5),(11,5),(12,5),(10,6),(11,6),(12,6), all colour 101.
  - done in the next cycle, then ready=1.
- Full-screen clear: x0=0, y0=0, w=160, h=120, color=0.
  - Required: 19200 consecutive plot cycles; last write at (159,119); single done pulse.
- Clipping: x0=158, y0=118, w=5, h=5.
  - Required: 4 plots at (158,118),(159,118),(158,119),(159,119).
- Empty and out-of-range commands: w=0; and x0=160, w=4.
  - Required: zero plots in each case; done pulses one cycle after start.
- Stall and ignored start: w=4, h=1 with stall high for 3 cycles after the 2nd pixel, and start pulsed mid-fill.
  - Required: exactly 4 plots, none repeated or skipped; total 7 FILL cycles.
  - The mid-fill start is ignored.
- Reset mid-fill: resetn low after 50 pixels of a 100-pixel fill.
  - Required: plot=0 immediately, ready=1 and done=0 after release, no further plots.
  - A new start is then accepted normally.
